// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Multi-cycle RV32I main control FSM (FETCH/DECODE/EXEC/MEM/WB)
//                with a bounded req/ready memory handshake. Define
//                MCU_ILLEGAL_TRAP_EN to trap on illegal opcodes (adds illegal_op).
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               RegWrite,
    output logic               MemToReg,
    output logic               ALUSrc,
    output logic               Branch,
    output logic               Jump,
    output logic               JumpReg,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               mem_timeout,
    output logic [2:0]         state_o
`ifdef MCU_ILLEGAL_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LD   = 7'b0000011;
    localparam logic [6:0] c_OP_ST   = 7'b0100011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;

    localparam logic [ALUOP_W-1:0] c_ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] c_ALU_BR  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_ALU_FN  = ALUOP_W'(2);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [6:0]         r_opcode_q;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_next;

    logic               w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jal, w_is_jalr;
    logic               w_legal_in;
    logic               w_at_limit;
    logic               w_alusrc_cls;
    logic [ALUOP_W-1:0] w_aluop_cls;

    assign w_is_r    = (r_opcode_q == c_OP_R);
    assign w_is_i    = (r_opcode_q == c_OP_I);
    assign w_is_ld   = (r_opcode_q == c_OP_LD);
    assign w_is_st   = (r_opcode_q == c_OP_ST);
    assign w_is_br   = (r_opcode_q == c_OP_BR);
    assign w_is_jal  = (r_opcode_q == c_OP_JAL);
    assign w_is_jalr = (r_opcode_q == c_OP_JALR);

    assign w_legal_in = (opcode == c_OP_R)  || (opcode == c_OP_I)   || (opcode == c_OP_LD) ||
                        (opcode == c_OP_ST) || (opcode == c_OP_BR)  || (opcode == c_OP_JAL) ||
                        (opcode == c_OP_JALR);

    assign w_at_limit = (r_wait_cnt == c_CNT_LAST);

    // Operand class of the latched instruction; held through EXEC, MEM and WB.
    assign w_alusrc_cls = w_is_i | w_is_ld | w_is_st | w_is_jalr;
    assign w_aluop_cls  = (w_is_r | w_is_i) ? c_ALU_FN :
                          w_is_br           ? c_ALU_BR : c_ALU_ADD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_opcode_q <= 7'd0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (r_state == S_DECODE) begin
                r_opcode_q <= opcode;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        RegWrite     = 1'b0;
        MemToReg     = 1'b0;
        ALUSrc       = 1'b0;
        Branch       = 1'b0;
        Jump         = 1'b0;
        JumpReg      = 1'b0;
        ALUOp        = c_ALU_ADD;
        mem_timeout  = 1'b0;
        state_o      = r_state;
`ifdef MCU_ILLEGAL_TRAP_EN
        illegal_op   = 1'b0;
`endif

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we        = 1'b1;
                    pc_we        = 1'b1;
                    pc_src       = 2'b00;
                    w_state_next = S_DECODE;
                end else if (w_at_limit) begin
                    mem_timeout  = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_wait_next  = r_wait_cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (w_legal_in) begin
                    w_state_next = S_EXEC;
                end else begin
`ifdef MCU_ILLEGAL_TRAP_EN
                    w_state_next = S_TRAP;
`else
                    w_state_next = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                ALUSrc  = w_alusrc_cls;
                ALUOp   = w_aluop_cls;
                Jump    = w_is_jal | w_is_jalr;
                JumpReg = w_is_jalr;
                if (w_is_br) begin
                    // PC write is qualified by the datapath's compare result.
                    Branch       = 1'b1;
                    pc_src       = 2'b01;
                    pc_we        = 1'b1;
                    w_state_next = S_FETCH;
                end else if (w_is_jal || w_is_jalr) begin
                    pc_src       = w_is_jalr ? 2'b11 : 2'b10;
                    pc_we        = 1'b1;
                    w_state_next = S_WB;
                end else if (w_is_ld || w_is_st) begin
                    w_state_next = S_MEM;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_st;
                ALUSrc  = w_alusrc_cls;
                ALUOp   = w_aluop_cls;
                Jump    = w_is_jal | w_is_jalr;
                JumpReg = w_is_jalr;
                if (mem_ready) begin
                    w_state_next = w_is_ld ? S_WB : S_FETCH;
                end else if (w_at_limit) begin
                    // Aborted data access retires as a NOP.
                    mem_timeout  = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_wait_next  = r_wait_cnt + CNT_W'(1);
                end
            end
            S_WB: begin
                RegWrite     = 1'b1;
                MemToReg     = w_is_ld;
                ALUSrc       = w_alusrc_cls;
                ALUOp        = w_aluop_cls;
                Jump         = w_is_jal | w_is_jalr;
                JumpReg      = w_is_jalr;
                w_state_next = S_FETCH;
            end
`ifdef MCU_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_op   = 1'b1;
                w_state_next = S_TRAP;
            end
`endif
            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        // Everything is quiet while reset is held, whatever the register contents.
        if (rst) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_src      = 2'b00;
            RegWrite    = 1'b0;
            MemToReg    = 1'b0;
            ALUSrc      = 1'b0;
            Branch      = 1'b0;
            Jump        = 1'b0;
            JumpReg     = 1'b0;
            ALUOp       = c_ALU_ADD;
            mem_timeout = 1'b0;
            state_o     = 3'd0;
`ifdef MCU_ILLEGAL_TRAP_EN
            illegal_op  = 1'b0;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_fsm
//  Description : Scoreboard bench for multicycle_control_fsm using directed
//                per-cycle vectors with hand-computed expected outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    bit         clk;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       RegWrite, MemToReg, ALUSrc, Branch, Jump, JumpReg;
    logic [1:0] ALUOp;
    logic       mem_timeout;
    logic [2:0] state_o;
    logic       w_ill;

    localparam logic [6:0] c_ADD  = 7'b0110011;
    localparam logic [6:0] c_ADDI = 7'b0010011;
    localparam logic [6:0] c_LW   = 7'b0000011;
    localparam logic [6:0] c_SW   = 7'b0100011;
    localparam logic [6:0] c_BEQ  = 7'b1100011;
    localparam logic [6:0] c_JAL  = 7'b1101111;
    localparam logic [6:0] c_JALR = 7'b1100111;
    localparam logic [6:0] c_ILL  = 7'b0000000;

    multicycle_control_fsm #(
        .ALUOP_W     (2),
        .MEM_TIMEOUT (15),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .RegWrite    (RegWrite),
        .MemToReg    (MemToReg),
        .ALUSrc      (ALUSrc),
        .Branch      (Branch),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .ALUOp       (ALUOp),
        .mem_timeout (mem_timeout),
        .state_o     (state_o)
`ifdef MCU_ILLEGAL_TRAP_EN
        ,
        .illegal_op  (w_ill)
`endif
    );

`ifndef MCU_ILLEGAL_TRAP_EN
    assign w_ill = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [18:0] exp_q[$];
    string       name_q[$];
    bit          done;
    int          checks;
    int          errors;
    int          pushed;

    // Vector layout: {state, req, we, ir_we, pc_we, pc_src, RegWrite, MemToReg,
    //                 ALUSrc, Branch, Jump, JumpReg, ALUOp, mem_timeout, illegal_op}
    function automatic logic [18:0] mk(input logic [2:0] st, input logic req, input logic we,
                                       input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                       input logic rw, input logic m2r, input logic asrc,
                                       input logic br, input logic j, input logic jr,
                                       input logic [1:0] aop, input logic to, input logic ill);
        return {st, req, we, irwe, pcwe, pcs, rw, m2r, asrc, br, j, jr, aop, to, ill};
    endfunction

    function automatic logic [18:0] v_zero();
        return mk(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] v_fetch_rdy();
        return mk(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] v_fetch_wait(input logic to);
        return mk(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, to, 0);
    endfunction
    function automatic logic [18:0] v_decode();
        return mk(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] v_exec(input logic pcwe, input logic [1:0] pcs, input logic asrc,
                                           input logic br, input logic j, input logic jr,
                                           input logic [1:0] aop);
        return mk(3'd2, 0, 0, 0, pcwe, pcs, 0, 0, asrc, br, j, jr, aop, 0, 0);
    endfunction
    function automatic logic [18:0] v_mem(input logic we, input logic to);
        return mk(3'd3, 1, we, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, to, 0);
    endfunction
    function automatic logic [18:0] v_wb(input logic m2r, input logic asrc, input logic j,
                                         input logic jr, input logic [1:0] aop);
        return mk(3'd4, 0, 0, 0, 0, 2'b00, 1, m2r, asrc, 0, j, jr, aop, 0, 0);
    endfunction
    function automatic logic [18:0] v_trap();
        return mk(3'd5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    endfunction

    task automatic cyc(input logic r, input logic rdy, input logic [6:0] op,
                       input string nm, input logic [18:0] e);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        opcode    = op;
        exp_q.push_back(e);
        name_q.push_back(nm);
        pushed++;
    endtask

    // Stimulus
    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 7'd0;
        done      = 1'b0;
        pushed    = 0;

        cyc(1, 1, c_ADD, "rst_c0", v_zero());
        cyc(1, 1, c_ADD, "rst_c1", v_zero());

        cyc(0, 1, c_ADD, "add_fetch",  v_fetch_rdy());
        cyc(0, 1, c_ADD, "add_decode", v_decode());
        cyc(0, 1, c_ADD, "add_exec",   v_exec(0, 2'b00, 0, 0, 0, 0, 2'b10));
        cyc(0, 1, c_ADD, "add_wb",     v_wb(0, 0, 0, 0, 2'b10));

        cyc(0, 1, c_ADDI, "addi_fetch",  v_fetch_rdy());
        cyc(0, 1, c_ADDI, "addi_decode", v_decode());
        cyc(0, 1, c_ADDI, "addi_exec",   v_exec(0, 2'b00, 1, 0, 0, 0, 2'b10));
        cyc(0, 1, c_ADDI, "addi_wb",     v_wb(0, 1, 0, 0, 2'b10));

        cyc(0, 1, c_LW, "lw_fetch",  v_fetch_rdy());
        cyc(0, 1, c_LW, "lw_decode", v_decode());
        cyc(0, 1, c_LW, "lw_exec",   v_exec(0, 2'b00, 1, 0, 0, 0, 2'b00));
        for (int i = 0; i < 3; i++) cyc(0, 0, c_LW, "lw_mem_wait", v_mem(0, 0));
        cyc(0, 1, c_LW, "lw_mem_done", v_mem(0, 0));
        cyc(0, 1, c_LW, "lw_wb",       v_wb(1, 1, 0, 0, 2'b00));

        cyc(0, 1, c_SW, "sw_fetch",  v_fetch_rdy());
        cyc(0, 1, c_SW, "sw_decode", v_decode());
        cyc(0, 1, c_SW, "sw_exec",   v_exec(0, 2'b00, 1, 0, 0, 0, 2'b00));
        for (int i = 0; i < 14; i++) cyc(0, 0, c_SW, "sw_mem_wait", v_mem(1, 0));
        cyc(0, 0, c_SW, "sw_mem_abort", v_mem(1, 1));

        cyc(0, 1, c_SW, "sw2_fetch",  v_fetch_rdy());
        cyc(0, 1, c_SW, "sw2_decode", v_decode());
        cyc(0, 1, c_SW, "sw2_exec",   v_exec(0, 2'b00, 1, 0, 0, 0, 2'b00));
        for (int i = 0; i < 14; i++) cyc(0, 0, c_SW, "sw2_mem_wait", v_mem(1, 0));
        cyc(0, 1, c_SW, "sw2_done_at_limit", v_mem(1, 0));

        for (int i = 0; i < 14; i++) cyc(0, 0, c_BEQ, "fetch_wait", v_fetch_wait(0));
        cyc(0, 0, c_BEQ, "fetch_abort", v_fetch_wait(1));

        cyc(0, 1, c_BEQ, "beq_fetch",  v_fetch_rdy());
        cyc(0, 1, c_BEQ, "beq_decode", v_decode());
        cyc(0, 1, c_BEQ, "beq_exec",   v_exec(1, 2'b01, 0, 1, 0, 0, 2'b01));

        cyc(0, 1, c_JAL, "jal_fetch",  v_fetch_rdy());
        cyc(0, 1, c_JAL, "jal_decode", v_decode());
        cyc(0, 1, c_JAL, "jal_exec",   v_exec(1, 2'b10, 0, 0, 1, 0, 2'b00));
        cyc(0, 1, c_JAL, "jal_wb",     v_wb(0, 0, 1, 0, 2'b00));

        cyc(0, 1, c_JALR, "jalr_fetch",  v_fetch_rdy());
        cyc(0, 1, c_JALR, "jalr_decode", v_decode());
        cyc(0, 1, c_JALR, "jalr_exec",   v_exec(1, 2'b11, 1, 0, 1, 1, 2'b00));
        cyc(0, 1, c_JALR, "jalr_wb",     v_wb(0, 1, 1, 1, 2'b00));

        cyc(0, 1, c_LW, "lw3_fetch",    v_fetch_rdy());
        cyc(0, 1, c_LW, "lw3_decode",   v_decode());
        cyc(0, 1, c_LW, "lw3_exec",     v_exec(0, 2'b00, 1, 0, 0, 0, 2'b00));
        cyc(0, 0, c_LW, "lw3_mem_wait", v_mem(0, 0));
        cyc(1, 1, c_LW, "mid_rst",      v_zero());
        cyc(0, 0, c_ADD, "post_rst_fetch_wait", v_fetch_wait(0));
        cyc(0, 1, c_ADD, "post_rst_fetch", v_fetch_rdy());
        cyc(0, 1, c_ADD, "post_rst_decode", v_decode());
        cyc(0, 1, c_ADD, "post_rst_exec", v_exec(0, 2'b00, 0, 0, 0, 0, 2'b10));
        cyc(0, 1, c_ADD, "post_rst_wb",   v_wb(0, 0, 0, 0, 2'b10));

        cyc(0, 1, c_ILL, "ill_fetch",  v_fetch_rdy());
        cyc(0, 1, c_ILL, "ill_decode", v_decode());
`ifdef MCU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) cyc(0, 1, c_ILL, "ill_trap", v_trap());
        cyc(1, 1, c_ADD, "trap_rst", v_zero());
`endif
        cyc(0, 1, c_ADD, "after_ill_fetch",  v_fetch_rdy());
        cyc(0, 1, c_ADD, "after_ill_decode", v_decode());

        done = 1'b1;
    end

    // Monitor: one expected vector per cycle, sampled mid-cycle on the falling edge
    initial begin
        logic [18:0] act;
        logic [18:0] exp_v;
        string       nm;
        checks = 0;
        errors = 0;
        while (!(done && exp_q.size() == 0)) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act   = {state_o, mem_req, mem_we, ir_we, pc_we, pc_src, RegWrite, MemToReg,
                         ALUSrc, Branch, Jump, JumpReg, ALUOp, mem_timeout, w_ill};
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b (state got %0d expected %0d)",
                             nm, act, exp_v, act[18:16], exp_v[18:16]);
                end
            end
        end
        if (checks != pushed) begin
            errors++;
            $display("FAIL count: %0d checks for %0d vectors", checks, pushed);
        end
        if (checks < 12) begin
            errors++;
            $display("FAIL coverage: only %0d checks", checks);
        end
        if (name_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d names left over", name_q.size());
        end
        if (errors != 0) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
